// File: rtl/cla_operand_loader.sv
// Operand feeder and result capture for the combinational CLA adder (cla_64bit).
// Optional carry-out register enabled by defining CLA_LOADER_COUT_EN.
module cla_operand_loader #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_cin,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_cin,
  input  logic [DATA_W-1:0] add_sum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_cout,
  output logic              busy
);

  localparam int unsigned NWORDS = DATA_W / WORD_W;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    SETTLE,
    HOLD
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;

  // Decoded from state so in_ready is already high on the first cycle out of reset.
  assign in_ready = ~reset & ((state == LOAD_A) || (state == LOAD_B));
  assign busy     = ~((state == LOAD_A) && (idx == '0));
  assign accept   = in_valid & in_ready;
  assign capture  = (state == SETTLE) && (cnt == LAST_CNT);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= LOAD_A;
      idx       <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      res_sum   <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            op_a[idx*WORD_W +: WORD_W] <= in_word;
            if (idx == '0) op_cin <= in_cin;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            op_b[idx*WORD_W +: WORD_W] <= in_word;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              cnt   <= '0;
              state <= SETTLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        SETTLE: begin
          // Capture lands on the SETTLE_CYC-th edge after the last B word.
          if (capture) begin
            res_sum   <= add_sum;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

`ifdef CLA_LOADER_COUT_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      res_cout <= 1'b0;
    end else if (capture) begin
      res_cout <= (op_a[DATA_W-1] & op_b[DATA_W-1]) |
                  ((op_a[DATA_W-1] ^ op_b[DATA_W-1]) & ~add_sum[DATA_W-1]);
    end
  end
`else
  assign res_cout = 1'b0;
`endif

endmodule

// File: tb/tb_cla_operand_loader.sv
// Directed bench for cla_operand_loader; the adder is modelled behaviourally here.
module tb_cla_operand_loader;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_word = '0;
  logic        in_cin = 1'b0;
  logic [63:0] op_a, op_b;
  logic        op_cin;
  logic [63:0] add_sum;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_sum;
  logic        res_cout;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef CLA_LOADER_COUT_EN
  localparam bit COUT_EN = 1'b1;
`else
  localparam bit COUT_EN = 1'b0;
`endif

  cla_operand_loader #(
    .WORD_W    (16),
    .DATA_W    (64),
    .SETTLE_CYC(4)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .in_cin   (in_cin),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
    .add_sum  (add_sum),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_cout (res_cout),
    .busy     (busy)
  );

  assign add_sum = op_a + op_b + {63'd0, op_cin};

  always #5 CLK = ~CLK;

  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          busy_mon = 1'b0;
  bit          busy_drop = 1'b0;
  logic [63:0] q_sum[$];
  int          q_cyc[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mon_en && res_valid) begin
      q_sum.push_back(res_sum);
      q_cyc.push_back(cyc);
    end
    if (busy_mon && !busy) busy_drop = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic c);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_word  = w;
    in_cin   = c;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                         input bit gapped);
    for (int i = 0; i < 8; i++) begin
      logic [63:0] v;
      v = (i < 4) ? a : b;
      send_word(v[(i % 4)*16 +: 16], c);
      if (i == 0) busy_mon = gapped;
      if (gapped && i < 7) repeat ((i % 3) + 1) tick();
    end
  endtask

  task automatic wait_result(output int unsigned n);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    if (!res_valid) check("res_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_result();
    res_ready = 1'b1;
    tick();
    check("res_valid_drop", {63'd0, res_valid}, 64'd0);
    res_ready = 1'b0;
  endtask

  localparam logic [63:0] A2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] B2 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] S2 = 64'h1234_5678_9ABC_DF01;

  initial begin
    int unsigned lat;
    logic [63:0] ra[3], rb[3];
    logic        rc[3];

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_sum", res_sum, 64'd0);
    check("rst_op_a", op_a, 64'd0);
    check("rst_op_cin", {63'd0, op_cin}, 64'd0);
    check("rst_res_cout", {63'd0, res_cout}, 64'd0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Test 1: 1 + all-ones wraps to 0 with carry out
    load_op(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    check("t1_settle_in_ready", {63'd0, in_ready}, 64'd0);
    wait_result(lat);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_sum", res_sum, 64'd0);
    check("t1_cout", {63'd0, res_cout}, {63'd0, COUT_EN});
    check("t1_op_a", op_a, 64'h1);
    finish_result();
    check("t1_busy_after", {63'd0, busy}, 64'd0);

    // Test 2
    load_op(A2, B2, 1'b1, 1'b0);
    wait_result(lat);
    check("t2_sum", res_sum, S2);
    check("t2_cout", {63'd0, res_cout}, 64'd0);
    check("t2_op_cin", {63'd0, op_cin}, 64'd1);
    finish_result();

    // Test 3: idle gaps between words, busy must not drop
    busy_drop = 1'b0;
    load_op(A2, B2, 1'b1, 1'b1);
    wait_result(lat);
    busy_mon = 1'b0;
    check("t3_sum", res_sum, S2);
    check("t3_busy_drop", {63'd0, busy_drop}, 64'd0);

    // Test 4: downstream stall with upstream pushing
    in_valid = 1'b1;
    in_word  = 16'hDEAD;
    in_cin   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t4_res_valid", {63'd0, res_valid}, 64'd1);
      check("t4_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    in_valid = 1'b0;
    check("t4_sum", res_sum, S2);
    check("t4_op_a", op_a, A2);
    check("t4_op_b", op_b, B2);
    check("t4_op_cin", {63'd0, op_cin}, 64'd1);
    finish_result();

    // Test 5: reset after two B words
    for (int i = 0; i < 6; i++) begin
      logic [63:0] v;
      v = (i < 4) ? 64'hAAAA_BBBB_CCCC_DDDD : 64'h5555_6666_7777_8888;
      send_word(v[(i % 4)*16 +: 16], 1'b1);
    end
    reset = 1'b1;
    #2;
    check("t5_op_a", op_a, 64'd0);
    check("t5_op_b", op_b, 64'd0);
    check("t5_res_valid", {63'd0, res_valid}, 64'd0);
    check("t5_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_busy", {63'd0, busy}, 64'd0);
    load_op(A2, B2, 1'b1, 1'b0);
    wait_result(lat);
    check("t5_sum", res_sum, S2);
    finish_result();

    // Test 6: back-to-back adds with res_ready held high
    for (int t = 0; t < 3; t++) begin
      ra[t] = {$urandom, $urandom};
      rb[t] = {$urandom, $urandom};
      rc[t] = 1'($urandom_range(0, 1));
    end
    ra[0][63] = 1'b1;
    rb[0][63] = 1'b1;
    res_ready = 1'b1;
    mon_en    = 1'b1;
    for (int t = 0; t < 3; t++) load_op(ra[t], rb[t], rc[t], 1'b0);
    repeat (20) tick();
    mon_en    = 1'b0;
    res_ready = 1'b0;
    check("t6_count", 64'(q_sum.size()), 64'd3);
    for (int t = 0; t < q_sum.size() && t < 3; t++) begin
      check($sformatf("t6_sum%0d", t), q_sum[t], ra[t] + rb[t] + {63'd0, rc[t]});
      if (t > 0) check($sformatf("t6_space%0d", t), 64'(q_cyc[t] - q_cyc[t-1]), 64'd13);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
